fb_store_queue: RTL and testbench
=================================

// Module: fb_store_queue
// PURPOSE
//  Downstream neighbour of the memory stage: captures stores (MemWriteM) that hit the frame-buffer window.
//  Each captured store goes into a small FIFO and is drained to the frame-buffer RAM port over a req/ack handshake.
//  Raises StallM to freeze the pipeline when the queue is full.
//  Stores outside the window are ignored; the data memory handles them.
// PARAMETERS
//  DATA_W   33            datapath width, matches ALU_ResultM/WriteDataM
//  DEPTH    4             FIFO entries, power of two, >=2
//  FB_BASE  33'h0001_0000 first byte address of frame-buffer window
//  FB_WORDS 4096          window size in 32-bit words, power of two
//  FB_AW    12            log2(FB_WORDS), width of fb_addr
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  MemWriteM    in   1       store valid in memory stage
//  ALU_ResultM  in   DATA_W  store byte address
//  WriteDataM   in   DATA_W  store data
//  RGB_M        in   2       channel select: 00 full word, 01 R, 10 G, 11 B
//  StallM       out  1       hold pipeline, store not accepted this cycle
//  fb_req       out  1       frame-buffer write request
//  fb_addr      out  FB_AW   word index inside window
//  fb_data      out  DATA_W  write data
//  fb_mask      out  4       byte-lane enable
//  fb_ack       in   1       write completed this cycle
//  q_empty      out  1       no pending entries and no request in flight
//  q_count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset values
//   - Async reset clears all state: FIFO pointers and count = 0, FSM = IDLE.
//   - Outputs during reset: fb_req=0, fb_addr=0, fb_data=0, fb_mask=0, q_empty=1, q_count=0, StallM=0.
//   - Reset mid-handshake drops fb_req immediately; the in-flight write is abandoned.
//  Hit and mask
//   - hit = MemWriteM && ALU_ResultM >= FB_BASE && ALU_ResultM < FB_BASE + 4*FB_WORDS.
//   - Address arithmetic is unsigned, DATA_W bits.
//   - Word index = (ALU_ResultM - FB_BASE) >> 2, truncated to FB_AW bits.
//   - RGB_M to mask: 00 -> 4'b1111, 01 -> 4'b0100, 10 -> 4'b0010, 11 -> 4'b0001.
//  StallM
//   - Combinational: StallM = hit && full.
//   - No same-cycle bypass of a concurrent pop; pipeline holds the store and retries next cycle.
//  Push
//   - On a clock edge with hit && !full, {index, WriteDataM, mask} is written at the tail.
//   - Push and pop in the same cycle are both honoured; count stays unchanged.
//   - Pointers wrap modulo DEPTH.
//  Drain FSM: IDLE, ISSUE
//   - IDLE: if FIFO non-empty, load head into output regs, fb_req<=1, go to ISSUE.
//   - ISSUE: fb_req, fb_addr, fb_data, fb_mask held stable until fb_ack.
//     - On fb_ack: pop head.
//     - If another entry remains (after any same-cycle push), load it and stay in ISSUE with fb_req=1 (back-to-back, 1 write/cycle).
//     - Otherwise fb_req<=0 and return to IDLE.
//   - fb_ack while fb_req=0 is ignored.
//  Latency
//   - Store accepted at edge N gives fb_req=1 in cycle N+1 when the queue was empty.
//  Status outputs
//   - q_empty = (count==0) && state==IDLE.
//   - q_count includes the entry being issued; it is popped only on ack.
// STRUCTURE
//  - Shared package proc_pkg:
//    - DATA_W.
//    - rgb_sel_e enum {RGB_FULL, RGB_R, RGB_G, RGB_B}.
//    - FB_BASE, FB_WORDS constants.
//    - fb_entry_t struct {addr, data, mask}.
//  - One sub-module, store_fifo:
//    - Generic DEPTH x fb_entry_t FIFO.
//    - Provides full, empty, count, push, pop, head.
//  - The top holds the hit/mask logic and the drain FSM.
// TESTING
//  1 Single store: MemWriteM=1, ALU_ResultM=FB_BASE+8, WriteDataM=33'h0FF0000, RGB_M=00.
//    -> Next cycle fb_req=1, fb_addr=2, fb_mask=4'hF.
//    -> Ack gives q_empty=1 one cycle later.
//  2 Out of window: store to FB_BASE-4 and to FB_BASE+4*FB_WORDS.
//    -> fb_req stays 0, q_count stays 0, StallM=0.
//  3 Fill and stall: 5 consecutive hits with fb_ack=0, DEPTH=4.
//    -> q_count=4; StallM=1 on the 5th until the first ack, then 5th accepted; 5 writes in order.
//  4 Back-to-back drain: 4 queued entries, fb_ack held 1.
//    -> 4 consecutive cycles of fb_req=1 with addresses in push order, then IDLE.
//  5 Channel masks: RGB_M=01/10/11 to FB_BASE+12.
//    -> fb_mask 4'b0100/4'b0010/4'b0001, fb_addr=3 each.
//  6 Reset mid-ISSUE: assert rst while fb_req=1, 3 entries queued.
//    -> fb_req=0 the same cycle, q_count=0, q_empty=1; no write after release.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor-side definitions for the frame-buffer store path:
// window constants, channel-select encoding and the queued store entry.
package proc_pkg;

  localparam int DATA_W   = 33;
  localparam int FB_WORDS = 4096;
  localparam int FB_AW    = $clog2(FB_WORDS);

  localparam logic [DATA_W-1:0] FB_BASE = 33'h0_0001_0000;
  // First byte address past the window.
  localparam logic [DATA_W-1:0] FB_END  = FB_BASE + DATA_W'(4 * FB_WORDS);

  typedef enum logic [1:0] {
    RGB_FULL = 2'b00,
    RGB_R    = 2'b01,
    RGB_G    = 2'b10,
    RGB_B    = 2'b11
  } rgb_sel_e;

  typedef enum logic {
    DRAIN_IDLE,
    DRAIN_ISSUE
  } drain_state_e;

  typedef struct packed {
    logic [FB_AW-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic [3:0]        mask;
  } fb_entry_t;

  function automatic logic [3:0] rgb_mask(input rgb_sel_e sel);
    logic [3:0] mask;
    case (sel)
      RGB_R:   mask = 4'b0100;
      RGB_G:   mask = 4'b0010;
      RGB_B:   mask = 4'b0001;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// DEPTH-entry FIFO of frame-buffer store entries. It exposes the head and the
// entry behind it, so the drain logic can reload straight after a pop.
module store_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  fb_entry_t              wr_entry,
  output fb_entry_t              head,
  output fb_entry_t              next_head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fb_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + AW'(1)];

  // NOTE: the storage array has no reset; only pointers and count carry
  // state that matters, and leaving the RAM unreset lets it map to plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_store_queue.sv
// Captures memory-stage stores that hit the frame-buffer window, queues them
// and drains them to the frame-buffer RAM port over a req/ack handshake.
module fb_store_queue
  import proc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   MemWriteM,
  input  logic [DATA_W-1:0]      ALU_ResultM,
  input  logic [DATA_W-1:0]      WriteDataM,
  input  logic [1:0]             RGB_M,
  output logic                   StallM,
  output logic                   fb_req,
  output logic [FB_AW-1:0]       fb_addr,
  output logic [DATA_W-1:0]      fb_data,
  output logic [3:0]             fb_mask,
  input  logic                   fb_ack,
  output logic                   q_empty,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic         hit;
  logic         full;
  logic         empty;
  logic         do_push;
  logic         do_pop;
  fb_entry_t    push_entry;
  fb_entry_t    head;
  fb_entry_t    next_head;

  drain_state_e state_q, state_d;
  fb_entry_t    out_q, out_d;
  logic         req_d;

  assign hit = MemWriteM && (ALU_ResultM >= FB_BASE) && (ALU_ResultM < FB_END);

  assign push_entry.addr = FB_AW'((ALU_ResultM - FB_BASE) >> 2);
  assign push_entry.data = WriteDataM;
  assign push_entry.mask = rgb_mask(rgb_sel_e'(RGB_M));

  // A full queue stalls even if the head is acked this cycle; the store retries.
  assign StallM  = hit && full;
  assign do_push = hit && !full;

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .wr_entry  (push_entry),
    .head      (head),
    .next_head (next_head),
    .full      (full),
    .empty     (empty),
    .count     (q_count)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    req_d   = fb_req;
    do_pop  = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        // An empty queue with an incoming store forwards it, so fb_req
        // rises in the cycle right after the store is accepted.
        if (!empty) begin
          out_d   = head;
          req_d   = 1'b1;
          state_d = DRAIN_ISSUE;
        end else if (do_push) begin
          out_d   = push_entry;
          req_d   = 1'b1;
          state_d = DRAIN_ISSUE;
        end
      end
      DRAIN_ISSUE: begin
        if (fb_ack) begin
          do_pop = 1'b1;
          if (q_count > CW'(1)) begin
            out_d = next_head;
          end else if (do_push) begin
            out_d = push_entry;
          end else begin
            req_d   = 1'b0;
            state_d = DRAIN_IDLE;
          end
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = DRAIN_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRAIN_IDLE;
      out_q   <= '0;
      fb_req  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      fb_req  <= req_d;
    end
  end

  assign fb_addr = out_q.addr;
  assign fb_data = out_q.data;
  assign fb_mask = out_q.mask;
  assign q_empty = (q_count == '0) && (state_q == DRAIN_IDLE);

endmodule

// File: tb/tb_fb_store_queue.sv
// Directed bench for fb_store_queue: single store, window edges, fill/stall,
// back-to-back drain, channel masks and reset during a handshake.
module tb_fb_store_queue;
  import proc_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              MemWriteM;
  logic [DATA_W-1:0] ALU_ResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [1:0]        RGB_M;
  logic              StallM;
  logic              fb_req;
  logic [FB_AW-1:0]  fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic [3:0]        fb_mask;
  logic              fb_ack;
  logic              q_empty;
  logic [2:0]        q_count;

  int n_tests = 0;
  int n_fail  = 0;

  fb_store_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .MemWriteM   (MemWriteM),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .RGB_M       (RGB_M),
    .StallM      (StallM),
    .fb_req      (fb_req),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_mask     (fb_mask),
    .fb_ack      (fb_ack),
    .q_empty     (q_empty),
    .q_count     (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input int word, input logic [DATA_W-1:0] data, input logic [1:0] rgb);
    MemWriteM   = 1'b1;
    ALU_ResultM = FB_BASE + DATA_W'(4 * word);
    WriteDataM  = data;
    RGB_M       = rgb;
  endtask

  logic [3:0] mask_exp [3];

  initial begin
    mask_exp[0] = 4'b0100;
    mask_exp[1] = 4'b0010;
    mask_exp[2] = 4'b0001;

    rst = 1'b1; MemWriteM = 1'b0; ALU_ResultM = '0; WriteDataM = '0; RGB_M = 2'b00; fb_ack = 1'b0;
    #1;
    check("rst_req",   64'(fb_req),  64'(0));
    check("rst_addr",  64'(fb_addr), 64'(0));
    check("rst_data",  64'(fb_data), 64'(0));
    check("rst_mask",  64'(fb_mask), 64'(0));
    check("rst_empty", 64'(q_empty), 64'(1));
    check("rst_count", 64'(q_count), 64'(0));
    check("rst_stall", 64'(StallM),  64'(0));
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: single full-word store to word 2
    store(2, 33'h0FF0000, 2'b00);
    check("t1_stall", 64'(StallM), 64'(0));
    tick();
    MemWriteM = 1'b0;
    check("t1_req",   64'(fb_req),  64'(1));
    check("t1_addr",  64'(fb_addr), 64'(2));
    check("t1_data",  64'(fb_data), 64'(33'h0FF0000));
    check("t1_mask",  64'(fb_mask), 64'(4'hF));
    check("t1_count", 64'(q_count), 64'(1));
    check("t1_busy",  64'(q_empty), 64'(0));
    fb_ack = 1'b1;
    tick();
    fb_ack = 1'b0;
    check("t1_req_drop", 64'(fb_req),  64'(0));
    check("t1_empty",    64'(q_empty), 64'(1));

    // 2: just below and just past the window are ignored; last word hits
    MemWriteM = 1'b1; ALU_ResultM = FB_BASE - DATA_W'(4); WriteDataM = 33'h1; RGB_M = 2'b00;
    check("t2_lo_stall", 64'(StallM), 64'(0));
    tick();
    check("t2_lo_req",   64'(fb_req),  64'(0));
    check("t2_lo_count", 64'(q_count), 64'(0));
    ALU_ResultM = FB_BASE + DATA_W'(4 * FB_WORDS);
    check("t2_hi_stall", 64'(StallM), 64'(0));
    tick();
    check("t2_hi_req",   64'(fb_req),  64'(0));
    check("t2_hi_count", 64'(q_count), 64'(0));
    store(FB_WORDS - 1, 33'h1_2345_6789, 2'b00);
    tick();
    MemWriteM = 1'b0;
    check("t2_last_req",  64'(fb_req),  64'(1));
    check("t2_last_addr", 64'(fb_addr), 64'(12'hFFF));
    check("t2_last_data", 64'(fb_data), 64'(33'h1_2345_6789));
    fb_ack = 1'b1;
    tick();
    fb_ack = 1'b0;
    check("t2_empty", 64'(q_empty), 64'(1));

    // 3: fill to DEPTH with no ack, fifth store stalls until the first ack
    for (int i = 0; i < 4; i++) begin
      store(10 + i, DATA_W'(100 + i), 2'b00);
      check($sformatf("t3_stall_%0d", i), 64'(StallM), 64'(0));
      tick();
    end
    store(14, DATA_W'(104), 2'b00);
    check("t3_count_full", 64'(q_count), 64'(4));
    check("t3_stall_5th",  64'(StallM),  64'(1));
    check("t3_head_addr",  64'(fb_addr), 64'(10));
    check("t3_head_data",  64'(fb_data), 64'(100));
    tick();
    check("t3_still_full", 64'(q_count), 64'(4));
    check("t3_held_addr",  64'(fb_addr), 64'(10));
    fb_ack = 1'b1;
    check("t3_no_bypass", 64'(StallM), 64'(1));
    tick();
    fb_ack = 1'b0;
    check("t3_after_ack_addr",  64'(fb_addr), 64'(11));
    check("t3_after_ack_count", 64'(q_count), 64'(3));
    check("t3_unstall",         64'(StallM),  64'(0));
    tick();
    MemWriteM = 1'b0;
    check("t3_refull",    64'(q_count), 64'(4));
    check("t3_hold_addr", 64'(fb_addr), 64'(11));

    // 4: back-to-back drain of the four queued entries (11..14)
    fb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_req_%0d", i),   64'(fb_req),  64'(1));
      check($sformatf("t4_addr_%0d", i),  64'(fb_addr), 64'(12 + i));
      check($sformatf("t4_count_%0d", i), 64'(q_count), 64'(3 - i));
    end
    check("t4_last_data", 64'(fb_data), 64'(104));
    tick();
    fb_ack = 1'b0;
    check("t4_idle_req",   64'(fb_req),  64'(0));
    check("t4_idle_empty", 64'(q_empty), 64'(1));

    // Push and pop together with a single entry: the new store is forwarded
    store(20, DATA_W'(200), 2'b00);
    tick();
    store(21, DATA_W'(201), 2'b01);
    fb_ack = 1'b1;
    tick();
    MemWriteM = 1'b0;
    check("pp_req",   64'(fb_req),  64'(1));
    check("pp_addr",  64'(fb_addr), 64'(21));
    check("pp_mask",  64'(fb_mask), 64'(4'b0100));
    check("pp_count", 64'(q_count), 64'(1));
    tick();
    fb_ack = 1'b0;
    check("pp_empty", 64'(q_empty), 64'(1));

    // 5: channel masks to word 3
    for (int i = 0; i < 3; i++) begin
      store(3, DATA_W'(300 + i), 2'(i + 1));
      tick();
      MemWriteM = 1'b0;
      check($sformatf("t5_mask_%0d", i), 64'(fb_mask), 64'(mask_exp[i]));
      check($sformatf("t5_addr_%0d", i), 64'(fb_addr), 64'(3));
      fb_ack = 1'b1;
      tick();
      fb_ack = 1'b0;
    end
    check("t5_empty", 64'(q_empty), 64'(1));

    // 6: reset while a request is in flight with three entries queued
    for (int i = 0; i < 3; i++) begin
      store(5 + i, DATA_W'(500 + i), 2'b00);
      tick();
    end
    MemWriteM = 1'b0;
    check("t6_pre_req",   64'(fb_req),  64'(1));
    check("t6_pre_count", 64'(q_count), 64'(3));
    rst = 1'b1;
    #1;
    check("t6_req_drop", 64'(fb_req),  64'(0));
    check("t6_count",    64'(q_count), 64'(0));
    check("t6_empty",    64'(q_empty), 64'(1));
    tick();
    rst = 1'b0;
    fb_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_quiet_req_%0d", i), 64'(fb_req),  64'(0));
      check($sformatf("t6_quiet_cnt_%0d", i), 64'(q_count), 64'(0));
    end
    fb_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
